alu8_core: RTL and testbench
============================

Name: alu8_core

Overview:
- Registered 8-bit integer datapath with four operations: ripple-carry add with carry and signed-overflow flags, bitwise AND, bitwise XOR, and unsigned 8x8 multiply giving a 16-bit product.
- Sits between operand/opcode issue logic and the result consumer.
- Accepts one operation per cycle.
- Results are registered, with one-cycle latency.

Parameters:
- WIDTH, 8, operand width. The only supported value is 8; the product is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and opcode are valid this cycle.
- opcode  input  2  00 = ADD, 01 = AND, 10 = XOR, 11 = MUL.
- op_a  input  8  operand A.
- op_b  input  8  operand B.
- out_valid  output  1  result, product and flags are valid.
- result  output  8  ADD/AND/XOR result.
- product  output  16  MUL result.
- carry  output  1  ADD carry-out.
- overflow  output  1  ADD two's-complement overflow.

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, result, product, carry and overflow to 0.
  - Reset mid-operation discards the in-flight operation; nothing is emitted after release.
- Latency: an operation sampled at rising edge N (in_valid=1) appears on the outputs after edge N, with out_valid=1 for exactly that cycle.
- in_valid=0 at an edge: out_valid goes to 0; result, product, carry and overflow hold their previous values.
- Back-to-back: one operation per cycle. There is no backpressure and no stall.
- ADD (00):
  - {c, s} = op_a + op_b + 0, computed by an 8-stage ripple-carry chain.
  - carry = c.
  - overflow = (op_a[7] == op_b[7]) && (s[7] != op_a[7]).
  - result = s when overflow=0, otherwise result = 8'h00. carry is still reported when overflow=1.
  - product = 0.
- AND (01): result = op_a & op_b; carry = 0; overflow = 0; product = 0.
- XOR (10): result = op_a ^ op_b; carry = 0; overflow = 0; product = 0.
- MUL (11):
  - product = op_a * op_b, unsigned, full 16 bits, no truncation.
  - result = 0; carry = 0; overflow = 0.
  - Implemented as a shift-add array of ripple-carry adder rows: eight partial products op_a & {8{op_b[i]}}, accumulated combinationally within the single cycle.
- All combinational paths are fully specified for every opcode; there are no latches.
- Simulation $display output is not part of the design.

Decomposition:
- Package alu8_pkg:
  - opcode enum: OP_ADD=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_MUL=2'b11.
  - WIDTH constant.
- Sub-module rca8 (8-bit ripple-carry adder):
  - Inputs: a, b, cin. Outputs: sum, cout, ovf.
  - Built from full-adder bit cells.
  - Instantiated once for ADD and seven times as accumulation rows inside the multiplier array (generate loop).
- AND/XOR and the output mux/registers stay inline in alu8_core.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> all outputs go to 0 immediately. Release and hold in_valid=0 -> out_valid stays 0.
- ADD, no overflow: a=100, b=27 -> next cycle result=127, carry=0, overflow=0, product=0, out_valid=1.
- ADD, overflow:
  - a=100, b=28 -> overflow=1, result=0, carry=0.
  - a=0x80, b=0x80 -> overflow=1, carry=1, result=0.
  - a=200, b=100 -> result=44, carry=1, overflow=0.
- Logic ops:
  - AND a=0xF0, b=0x3C -> result=0x30, flags 0.
  - XOR same operands -> result=0xCC.
- MUL boundaries:
  - 255*255 -> product=0xFE01, result=0.
  - 0*200 -> product=0.
  - 16*16 -> product=0x0100.
- Back-to-back: issue ADD(1,2), AND(0xFF,0x0F), MUL(3,5) on consecutive cycles, then in_valid=0 -> outputs 3, then 0x0F, then product=15 on consecutive cycles. out_valid then drops; product stays 15.

Source files
------------

// File: rtl/alu8_pkg.sv
// Shared constants and opcode encoding for the alu8 datapath.
package alu8_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_MUL = 2'b11
  } opcode_e;

endpackage

// File: rtl/rca8.sv
// 8-bit ripple-carry adder built from full-adder bit cells, with sum,
// carry-out and two's-complement overflow.
module fa1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module rca8
  import alu8_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic w_ci;
      logic w_co;
      if (i == 0) begin : g_lsb
        assign w_ci = cin;
      end else begin : g_chain
        assign w_ci = g_bit[i-1].w_co;
      end
      fa1 u_fa (
        .i_a    (a[i]),
        .i_b    (b[i]),
        .i_cin  (w_ci),
        .o_sum  (sum[i]),
        .o_cout (w_co)
      );
    end
  endgenerate

  assign cout = g_bit[WIDTH-1].w_co;
  // Same-sign operands whose sum flips sign have left the signed range.
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu8_core.sv
// Registered 8-bit ALU: ADD with carry/overflow, AND, XOR and an unsigned
// 8x8 shift-add array multiplier; one-cycle latency, one op per cycle.
module alu8_core
  import alu8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  opcode,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        out_valid,
  output logic [7:0]  result,
  output logic [15:0] product,
  output logic        carry,
  output logic        overflow
);

  opcode_e w_op;
  assign w_op = opcode_e'(opcode);

  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;
  logic             w_add_ovf;

  rca8 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (w_add_sum),
    .cout (w_add_cout),
    .ovf  (w_add_ovf)
  );

  logic [WIDTH-1:0] w_pp [WIDTH];

  genvar p;
  generate
    for (p = 0; p < WIDTH; p++) begin : g_pp
      assign w_pp[p] = op_a & {WIDTH{op_b[p]}};
    end
  endgenerate

  // Each row adds the next partial product to the running sum shifted
  // right by one; the bit shifted out is a settled product bit.
  genvar r;
  generate
    for (r = 1; r < WIDTH; r++) begin : g_row
      logic [WIDTH-1:0] w_acc;
      logic [WIDTH-1:0] w_sum;
      logic             w_cout;
      logic             w_ovf_unused;
      if (r == 1) begin : g_first
        assign w_acc = {1'b0, w_pp[0][WIDTH-1:1]};
      end else begin : g_next
        assign w_acc = {g_row[r-1].w_cout, g_row[r-1].w_sum[WIDTH-1:1]};
      end
      rca8 u_row (
        .a    (w_acc),
        .b    (w_pp[r]),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout),
        .ovf  (w_ovf_unused)
      );
    end
  endgenerate

  logic [2*WIDTH-1:0] w_mul;
  assign w_mul = {g_row[7].w_cout, g_row[7].w_sum,
                  g_row[6].w_sum[0], g_row[5].w_sum[0], g_row[4].w_sum[0],
                  g_row[3].w_sum[0], g_row[2].w_sum[0], g_row[1].w_sum[0],
                  w_pp[0][0]};

  logic [WIDTH-1:0]   w_result;
  logic [2*WIDTH-1:0] w_product;
  logic               w_carry;
  logic               w_overflow;

  always_comb begin
    w_result   = '0;
    w_product  = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_result   = w_add_ovf ? '0 : w_add_sum;
        w_carry    = w_add_cout;
        w_overflow = w_add_ovf;
      end
      OP_AND:  w_result  = op_a & op_b;
      OP_XOR:  w_result  = op_a ^ op_b;
      OP_MUL:  w_product = w_mul;
      default: w_result  = '0;
    endcase
  end

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0] r_product;
  logic               r_carry;
  logic               r_overflow;

  // Output register stage: data only updates on accepted ops, so idle
  // cycles leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_product   <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_result;
        r_product  <= w_product;
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign product   = r_product;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu8_core.sv
// Directed-vector bench for alu8_core with hand-computed expectations.
module tb_alu8_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  opcode;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        out_valid;
  logic [7:0]  result;
  logic [15:0] product;
  logic        carry;
  logic        overflow;

  int total;
  int bad;

  alu8_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .result    (result),
    .product   (product),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [7:0] res,
                         input logic [15:0] prod, input logic c, input logic o);
    chk({tag, ".vld"},  {15'd0, out_valid}, {15'd0, vld});
    chk({tag, ".res"},  {8'd0, result},     {8'd0, res});
    chk({tag, ".prod"}, product,            prod);
    chk({tag, ".c"},    {15'd0, carry},     {15'd0, c});
    chk({tag, ".o"},    {15'd0, overflow},  {15'd0, o});
  endtask

  // Present an op on the falling edge, then sample just after the next rise.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    opcode   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 2'b00;
    op_a     = 8'd0;
    op_b     = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    do_op(2'b00, 8'd100, 8'd27);
    chk_out("add_100_27", 1'b1, 8'd127, 16'h0000, 1'b0, 1'b0);
    idle_cycle();
    chk_out("hold_127", 1'b0, 8'd127, 16'h0000, 1'b0, 1'b0);

    do_op(2'b00, 8'd100, 8'd28);
    chk_out("add_ovf_pos", 1'b1, 8'h00, 16'h0000, 1'b0, 1'b1);
    do_op(2'b00, 8'h80, 8'h80);
    chk_out("add_ovf_neg", 1'b1, 8'h00, 16'h0000, 1'b1, 1'b1);
    do_op(2'b00, 8'd200, 8'd100);
    chk_out("add_carry", 1'b1, 8'd44, 16'h0000, 1'b1, 1'b0);

    do_op(2'b01, 8'hF0, 8'h3C);
    chk_out("and", 1'b1, 8'h30, 16'h0000, 1'b0, 1'b0);
    do_op(2'b10, 8'hF0, 8'h3C);
    chk_out("xor", 1'b1, 8'hCC, 16'h0000, 1'b0, 1'b0);

    do_op(2'b11, 8'd255, 8'd255);
    chk_out("mul_max", 1'b1, 8'h00, 16'hFE01, 1'b0, 1'b0);
    do_op(2'b11, 8'd0, 8'd200);
    chk_out("mul_zero", 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
    do_op(2'b11, 8'd16, 8'd16);
    chk_out("mul_16", 1'b1, 8'h00, 16'h0100, 1'b0, 1'b0);
    do_op(2'b11, 8'hA5, 8'h3C);
    chk_out("mul_a5_3c", 1'b1, 8'h00, 16'h26AC, 1'b0, 1'b0);
    idle_cycle();

    do_op(2'b00, 8'd1, 8'd2);
    chk_out("b2b_add", 1'b1, 8'd3, 16'h0000, 1'b0, 1'b0);
    do_op(2'b01, 8'hFF, 8'h0F);
    chk_out("b2b_and", 1'b1, 8'h0F, 16'h0000, 1'b0, 1'b0);
    do_op(2'b11, 8'd3, 8'd5);
    chk_out("b2b_mul", 1'b1, 8'h00, 16'd15, 1'b0, 1'b0);
    idle_cycle();
    chk_out("b2b_drop", 1'b0, 8'h00, 16'd15, 1'b0, 1'b0);

    // Async reset mid-cycle while a result is valid and another op is in flight.
    do_op(2'b00, 8'd200, 8'd100);
    chk_out("pre_rst", 1'b1, 8'd44, 16'h0000, 1'b1, 1'b0);
    op_a = 8'd5;
    op_b = 8'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("in_rst", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_rst1", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("post_rst2", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
